// File: rtl/cmos_16_8bit_tx_pkg.sv
// Shared types and helpers for the 16->8 bit DVP transmitter.
// FSM state encoding, byte-phase encoding and counter sizing.
package cmos_16_8bit_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VSYNC  = 3'd1,
      ST_VBACK  = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_VFRONT = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      PH_FIRST  = 2'd0,
      PH_SECOND = 2'd1
   } phase_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/cmos_16_8bit_tx_timing.sv
// Frame timing for the DVP transmitter: h/v counters and frame FSM.
// Outputs decode registered state; the timing never stalls for the pixel source.
module cmos_16_8bit_tx_timing
   import cmos_16_8bit_tx_pkg::*;
#(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int H_BLANK   = 144,
   parameter int VSYNC_LEN = 3,
   parameter int V_BACK    = 17,
   parameter int V_FRONT   = 10
) (
   input  logic   pclk,
   input  logic   rst,
   input  logic   enable,
   output logic   line_active,
   output logic   pixel_slot,
   output phase_t phase,
   output logic   vsync,
   output logic   frame_start,
   output logic   busy
);

   localparam int L    = 2*H_ACTIVE + H_BLANK;
   localparam int VMAX = max4(VSYNC_LEN, V_BACK, V_ACTIVE, V_FRONT);
   localparam int HW   = cnt_w(L);
   localparam int VW   = cnt_w(VMAX);

   state_t          state, state_nx;
   logic [HW-1:0]   hcnt, hcnt_nx;
   logic [VW-1:0]   vcnt, vcnt_nx;
   logic            line_end, last_line;

   function automatic int lines_of(input state_t s);
      case (s)
         ST_VSYNC:  return VSYNC_LEN;
         ST_VBACK:  return V_BACK;
         ST_ACTIVE: return V_ACTIVE;
         ST_VFRONT: return V_FRONT;
         default:   return 1;
      endcase
   endfunction

   // Zero-line phases are skipped; enable is only looked at when a frame ends.
   function automatic state_t after(input state_t s, input logic en);
      case (s)
         ST_VSYNC:  return (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
         ST_VBACK:  return ST_ACTIVE;
         ST_ACTIVE: return (V_FRONT > 0) ? ST_VFRONT : (en ? ST_VSYNC : ST_IDLE);
         default:   return en ? ST_VSYNC : ST_IDLE;
      endcase
   endfunction

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         hcnt  <= '0;
         vcnt  <= '0;
      end else begin
         state <= state_nx;
         hcnt  <= hcnt_nx;
         vcnt  <= vcnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      hcnt_nx   = hcnt;
      vcnt_nx   = vcnt;
      line_end  = (hcnt == HW'(L-1));
      last_line = (vcnt == VW'(lines_of(state) - 1));
      if (state == ST_IDLE) begin
         if (enable) state_nx = ST_VSYNC;
      end else if (line_end) begin
         hcnt_nx = '0;
         if (last_line) begin
            vcnt_nx  = '0;
            state_nx = after(state, enable);
         end else begin
            vcnt_nx = vcnt + 1'b1;
         end
      end else begin
         hcnt_nx = hcnt + 1'b1;
      end
   end

   assign line_active = (state == ST_ACTIVE) && (hcnt < HW'(2*H_ACTIVE));
   assign phase       = hcnt[0] ? PH_SECOND : PH_FIRST;
   assign pixel_slot  = line_active && (phase == PH_FIRST);
   assign vsync       = (state == ST_VSYNC);
   assign frame_start = vsync && (hcnt == '0) && (vcnt == '0);
   assign busy        = (state != ST_IDLE);

endmodule

// File: rtl/cmos_16_8bit_tx.sv
// DVP transmitter: one 16-bit pixel per two pclk, serialized onto an 8-bit bus.
// First byte one cycle after acceptance; a missing pixel emits FILL_BYTE, never stalls.
module cmos_16_8bit_tx
   import cmos_16_8bit_tx_pkg::*;
#(
   parameter int         H_ACTIVE   = 640,
   parameter int         V_ACTIVE   = 480,
   parameter int         H_BLANK    = 144,
   parameter int         VSYNC_LEN  = 3,
   parameter int         V_BACK     = 17,
   parameter int         V_FRONT    = 10,
   parameter bit         SWAP_BYTES = 1'b0,
   parameter logic [7:0] FILL_BYTE  = 8'h00
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] pix_data_i,
   input  logic        pix_valid_i,
   output logic        pix_ready_o,
   output logic [7:0]  pdata_o,
   output logic        href_o,
   output logic        vsync_o,
   output logic        frame_start_o,
   output logic        underflow_o,
   output logic        busy_o
);

   logic        line_active, pixel_slot, vsync, frame_start, busy;
   phase_t      phase;
   logic [15:0] word_q;
   logic        have_q;

   cmos_16_8bit_tx_timing #(
      .H_ACTIVE  (H_ACTIVE),
      .V_ACTIVE  (V_ACTIVE),
      .H_BLANK   (H_BLANK),
      .VSYNC_LEN (VSYNC_LEN),
      .V_BACK    (V_BACK),
      .V_FRONT   (V_FRONT)
   ) u_timing (
      .pclk        (pclk),
      .rst         (rst),
      .enable      (enable),
      .line_active (line_active),
      .pixel_slot  (pixel_slot),
      .phase       (phase),
      .vsync       (vsync),
      .frame_start (frame_start),
      .busy        (busy)
   );

   assign pix_ready_o   = pixel_slot;
   assign vsync_o       = vsync;
   assign frame_start_o = frame_start;
   assign busy_o        = busy;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         pdata_o     <= '0;
         href_o      <= 1'b0;
         underflow_o <= 1'b0;
         word_q      <= '0;
         have_q      <= 1'b0;
      end else begin
         href_o      <= line_active;
         underflow_o <= 1'b0;
         if (!line_active) begin
            pdata_o <= '0;
         end else if (phase == PH_FIRST) begin
            if (pix_valid_i) begin
               word_q  <= pix_data_i;
               have_q  <= 1'b1;
               pdata_o <= SWAP_BYTES ? pix_data_i[15:8] : pix_data_i[7:0];
            end else begin
               have_q      <= 1'b0;
               pdata_o     <= FILL_BYTE;
               underflow_o <= 1'b1;
            end
         end else begin
            // Second byte comes from the held word, or fill if the slot was empty.
            pdata_o <= !have_q ? FILL_BYTE : (SWAP_BYTES ? word_q[7:0] : word_q[15:8]);
         end
      end
   end

endmodule

// File: tb/tb_cmos_16_8bit_tx.sv
// Directed bench for cmos_16_8bit_tx on a 4x2 frame (L=11, 55 cycles per frame).
module tb_cmos_16_8bit_tx;

   logic        pclk = 1'b0;
   logic        rst  = 1'b1;
   logic        enable = 1'b0;
   logic [15:0] pix_data_i = '0;
   logic        pix_valid_i = 1'b0;
   logic        pix_ready_o, href_o, vsync_o, frame_start_o, underflow_o, busy_o;
   logic [7:0]  pdata_o;

   logic        s_enable = 1'b0;
   logic [15:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready, s_href, s_vsync, s_fs, s_uf, s_busy;
   logic [7:0]  s_pdata;

   int tests = 0;
   int fails = 0;

   always #5 pclk = ~pclk;

   cmos_16_8bit_tx #(
      .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(3), .VSYNC_LEN(1), .V_BACK(1), .V_FRONT(1),
      .SWAP_BYTES(1'b0), .FILL_BYTE(8'h00)
   ) dut (
      .pclk(pclk), .rst(rst), .enable(enable),
      .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
      .pdata_o(pdata_o), .href_o(href_o), .vsync_o(vsync_o),
      .frame_start_o(frame_start_o), .underflow_o(underflow_o), .busy_o(busy_o)
   );

   cmos_16_8bit_tx #(
      .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(3), .VSYNC_LEN(1), .V_BACK(1), .V_FRONT(1),
      .SWAP_BYTES(1'b1), .FILL_BYTE(8'h00)
   ) dut_swap (
      .pclk(pclk), .rst(rst), .enable(s_enable),
      .pix_data_i(s_data), .pix_valid_i(s_valid), .pix_ready_o(s_ready),
      .pdata_o(s_pdata), .href_o(s_href), .vsync_o(s_vsync),
      .frame_start_o(s_fs), .underflow_o(s_uf), .busy_o(s_busy)
   );

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [13:0] outs();
      return {vsync_o, href_o, frame_start_o, pix_ready_o, busy_o, underflow_o, pdata_o};
   endfunction

   // Runs one 55-cycle frame; the next edge must start it. Vector per cycle:
   // {vsync, href, frame_start, ready, busy, underflow, pdata}.
   task automatic run_frame(input string name, input logic [15:0] base, input int uf_slot,
                            input int drop_at, output int n_acc, output int n_rdy, output int n_uf);
      logic [15:0] exp_w [8];
      bit          exp_fill [8];
      int          k, taken, line, h, pl, hp, s;
      logic        prev_acc, e_rdy, e_href, e_uf;
      logic [7:0]  e_pd;
      k = 0;
      for (int i = 0; i < 8; i++) begin
         exp_fill[i] = (i == uf_slot);
         exp_w[i]    = exp_fill[i] ? 16'h0000 : base + 16'(k);
         if (!exp_fill[i]) k++;
      end
      taken = 0; prev_acc = 1'b0; n_rdy = 0; n_uf = 0;
      pix_valid_i = 1'b1;
      pix_data_i  = base;
      for (int p = 0; p < 55; p++) begin
         tick();
         if (prev_acc) taken++;
         pix_data_i = base + 16'(taken);
         line  = p / 11;
         h     = p % 11;
         e_rdy = (line == 2 || line == 3) && h < 8 && (h % 2 == 0);
         e_href = 1'b0; e_uf = 1'b0; e_pd = 8'h00;
         if (p > 0) begin
            pl = (p-1) / 11;
            hp = (p-1) % 11;
            if ((pl == 2 || pl == 3) && hp < 8) begin
               s      = (pl-2)*4 + hp/2;
               e_href = 1'b1;
               e_uf   = (hp % 2 == 0) && exp_fill[s];
               e_pd   = exp_fill[s] ? 8'h00 : ((hp % 2 == 0) ? exp_w[s][7:0] : exp_w[s][15:8]);
            end
         end
         chk($sformatf("%s p%0d", name, p), 32'(outs()),
             32'({line == 0, e_href, p == 0, e_rdy, 1'b1, e_uf, e_pd}));
         n_rdy += int'(pix_ready_o);
         n_uf  += int'(underflow_o);
         pix_valid_i = !(e_rdy && ((line-2)*4 + h/2) == uf_slot);
         prev_acc    = pix_ready_o && pix_valid_i;
         if (p == drop_at) enable = 1'b0;
      end
      n_acc = taken;
   endtask

   initial begin
      int          n_acc, n_rdy, n_uf, nb, nrec, ngood;
      logic        any_out, rdy_seen, half;
      logic [7:0]  b0, first_b, second_b;
      logic [15:0] rec0;

      // Reset state and a long idle with enable low.
      #2;
      chk("reset outs", 32'(outs()), 32'h0);
      tick(); tick();
      rst = 1'b0;
      any_out = 1'b0; rdy_seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         any_out  |= |outs();
         rdy_seen |= pix_ready_o;
      end
      chk("idle outputs", 32'(any_out), 32'h0);
      chk("idle ready", 32'(rdy_seen), 32'h0);

      // Frame A: full frame of words 0x1100..0x1107.
      enable = 1'b1;
      run_frame("frameA", 16'h1100, -1, -1, n_acc, n_rdy, n_uf);
      chk("frameA accepted", 32'(n_acc), 32'd8);
      chk("frameA ready pulses", 32'(n_rdy), 32'd8);
      chk("frameA underflows", 32'(n_uf), 32'd0);

      // Frame B follows back-to-back; second slot of the first active line underflows.
      run_frame("frameB", 16'h2200, 1, -1, n_acc, n_rdy, n_uf);
      chk("frameB accepted", 32'(n_acc), 32'd7);
      chk("frameB underflows", 32'(n_uf), 32'd1);

      // Frame C: enable dropped at cycle 20, frame still completes.
      run_frame("frameC", 16'h3300, -1, 20, n_acc, n_rdy, n_uf);
      chk("frameC accepted", 32'(n_acc), 32'd8);
      tick();
      chk("after frameC busy", 32'(busy_o), 32'h0);
      chk("after frameC fs", 32'(frame_start_o), 32'h0);
      any_out = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         any_out |= frame_start_o | busy_o | vsync_o;
      end
      chk("no restart", 32'(any_out), 32'h0);

      // Swapped instance with a loopback packer using the same byte order.
      s_enable = 1'b1; s_valid = 1'b1; s_data = 16'hABCD;
      nb = 0; nrec = 0; ngood = 0; half = 1'b0;
      b0 = 8'h00; first_b = 8'h00; second_b = 8'h00; rec0 = 16'h0000;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (i == 1) s_enable = 1'b0;
         if (s_href) begin
            if (nb == 0) first_b = s_pdata;
            if (nb == 1) second_b = s_pdata;
            nb++;
            if (!half) b0 = s_pdata;
            else begin
               if (nrec == 0) rec0 = {b0, s_pdata};
               if ({b0, s_pdata} == 16'hABCD) ngood++;
               nrec++;
            end
            half = ~half;
         end
      end
      chk("swap first byte", 32'(first_b), 32'hAB);
      chk("swap second byte", 32'(second_b), 32'hCD);
      chk("loopback word", 32'(rec0), 32'hABCD);
      chk("loopback count", 32'(ngood), 32'd8);
      chk("swap idle after", 32'(s_busy), 32'h0);

      // Reset in the middle of an active line, then restart.
      enable = 1'b1; pix_valid_i = 1'b1; pix_data_i = 16'h4455;
      for (int i = 0; i < 26; i++) tick();
      chk("pre-reset href", 32'(href_o), 32'h1);
      rst = 1'b1;
      #1;
      chk("mid-line reset outs", 32'(outs()), 32'h0);
      tick(); tick();
      rst = 1'b0;
      chk("post-reset idle", 32'(busy_o), 32'h0);
      tick();
      chk("restart frame", 32'({frame_start_o, vsync_o, busy_o, href_o}), 32'b1110);
      tick();
      chk("restart fs pulse", 32'(frame_start_o), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
